// File: rtl/multi_counter_pkg.sv
// Shared defaults for the multi_counter event-counter bank.
package multi_counter_pkg;
  localparam int MC_AW_DEF = 4;
  localparam int MC_DW_DEF = 16;
endpackage

// File: rtl/multi_counter_cell.sv
// One DW-bit wrapping event counter with increment enable and async clear.
import multi_counter_pkg::*;

module multi_counter_cell #(
  parameter int DW = MC_DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [DW-1:0] count
);

  logic [DW-1:0] count_d;
  logic [DW-1:0] count_q;

  // Next count: modulo 2**DW increment when enabled.
  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = count_q + {{(DW-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {DW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/multi_counter.sv
// Bank of 2**AW event counters with a shared increment port and a registered read port.
import multi_counter_pkg::*;

module multi_counter #(
  parameter int AW = MC_AW_DEF,
  parameter int DW = MC_DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic [AW-1:0] inc_addr,
  input  logic [AW-1:0] read_addr,
  output logic [DW-1:0] read_data
);

  localparam int NUM = 2 ** AW;

  logic [DW-1:0] cnt_s [NUM];
  logic [DW-1:0] read_data_d;
  logic [DW-1:0] read_data_q;

  // inc gates the address decode, so an undefined inc_addr while idle enables nothing.
  for (genvar i = 0; i < NUM; i++) begin : g_cell
    logic en_s;
    assign en_s = inc & (inc_addr == AW'(i));

    multi_counter_cell #(.DW(DW)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en_s),
      .count (cnt_s[i])
    );
  end

  // Read mux: sees pre-increment values, so a same-edge read returns the old count.
  always_comb begin
    read_data_d = cnt_s[read_addr];
  end

  // Read data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_q <= {DW{1'b0}};
    end else begin
      read_data_q <= read_data_d;
    end
  end

  assign read_data = read_data_q;

endmodule

// File: tb/tb_multi_counter.sv
// Directed self-checking bench for multi_counter (AW=4, DW=16).
module tb_multi_counter;

  logic        clk;
  logic        rst_n;
  logic        inc;
  logic [3:0]  inc_addr;
  logic [3:0]  read_addr;
  logic [15:0] read_data;

  int checks;
  int failures;
  logic [15:0] exp_cnt [16];

  multi_counter #(.AW(4), .DW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (inc),
    .inc_addr  (inc_addr),
    .read_addr (read_addr),
    .read_data (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] exp, input string tag);
    read_addr = a;
    tick();
    chk(tag, read_data, exp);
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), exp_cnt[a], $sformatf("%s_a%0d", tag, a));
    end
  endtask

  task automatic clear_exp();
    for (int a = 0; a < 16; a++) exp_cnt[a] = 16'h0000;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    inc       = 1'b0;
    inc_addr  = 4'h0;
    read_addr = 4'h0;
    clear_exp();
    #23;
    chk("reset_rd", read_data, 16'h0000);
    rst_n = 1'b1;
    tick();

    // 1: all counters zero after reset
    sweep("s1");

    // 2: inc addr 4, then addr 3
    inc = 1'b1; inc_addr = 4'd4; tick();
    inc_addr = 4'd3; tick();
    inc = 1'b0;
    rd(4'd3, 16'h0001, "s2_c3");
    rd(4'd4, 16'h0001, "s2_c4");

    // 3: back-to-back on addr 4
    inc = 1'b1; inc_addr = 4'd4; tick(); tick();
    inc = 1'b0;
    rd(4'd4, 16'h0003, "s3_c4");

    // 4: two incs at addr 6, five cycles apart
    inc = 1'b1; inc_addr = 4'd6; tick();
    inc = 1'b0; repeat (4) tick();
    inc = 1'b1; inc_addr = 4'd6; tick();
    inc = 1'b0;
    exp_cnt[3] = 16'd1; exp_cnt[4] = 16'd3; exp_cnt[6] = 16'd2;
    sweep("s4");

    // 5: preload addr 0 to 0xFFFF, then wrap
    inc = 1'b1; inc_addr = 4'd0;
    repeat (65535) tick();
    inc = 1'b0;
    rd(4'd0, 16'hFFFF, "s5_full");
    inc = 1'b1; inc_addr = 4'd0; tick();
    inc = 1'b0;
    rd(4'd0, 16'h0000, "s5_wrap");
    inc_addr = 4'bxxxx;
    repeat (3) tick();
    inc_addr = 4'd0;
    sweep("s5_idle");

    // 6: same-edge read and increment of addr 5
    read_addr = 4'd5; inc = 1'b1; inc_addr = 4'd5; tick();
    inc = 1'b0;
    chk("s6_same_edge", read_data, 16'h0000);
    tick();
    chk("s6_next", read_data, 16'h0001);
    inc = 1'b1; inc_addr = 4'd5; tick();
    chk("s6_pre_rst", read_data, 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_async_rd", read_data, 16'h0000);
    inc = 1'b0;
    #15;
    rst_n = 1'b1;
    clear_exp();
    tick();
    sweep("s6_post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
